// File: rtl/vsfx_wb.sv
// Write-back stage for the vector simple fixed-point unit: in-order result FIFO draining into
// the VR file write port, plus sticky VSCR[SAT] and record-form CR6 update on retire.
module vsfx_wb #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vrt_en,
  input  logic [DW-1:0]              vrt,
  input  logic                       sat,
  input  logic [3:0]                 cr6,
  input  logic                       rc,
  input  logic [AW-1:0]              vrt_addr,
  input  logic                       vscr_clr,
  input  logic                       wb_ready,
  output logic                       vr_we,
  output logic [AW-1:0]              vr_waddr,
  output logic [DW-1:0]              vr_wdata,
  output logic                       cr6_we,
  output logic [3:0]                 cr6_out,
  output logic                       vscr_sat,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic          sat_mem  [DEPTH];
  logic [3:0]    cr6_mem  [DEPTH];
  logic          rc_mem   [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, sat_q, sat_d;
  logic [3:0]    cr6_q, cr6_d;
  logic          full_w, push, pop;

  always_comb begin
    full_w = (cnt_q == CW'(DEPTH));
    pop    = (cnt_q != '0) && wb_ready;
    // A pop frees a slot in the same cycle, so a push is accepted even when full.
    push   = vrt_en && (!full_w || pop);

    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(push);
    cnt_d  = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    if (pop && !push) cnt_d = cnt_q - CW'(1);

    ovf_d = ovf_q | (vrt_en & full_w & ~pop);

    // A retiring sat result is younger than the mtvscr, so set beats clear.
    sat_d = sat_q;
    if (vscr_clr) sat_d = 1'b0;
    if (pop && sat_mem[head_q]) sat_d = 1'b1;

    cr6_we  = 1'b0;
    cr6_out = cr6_q;
    cr6_d   = cr6_q;
    if (pop && rc_mem[head_q]) begin
      cr6_we  = 1'b1;
      cr6_out = cr6_mem[head_q];
      cr6_d   = cr6_mem[head_q];
    end

    vr_we    = (cnt_q != '0);
    vr_waddr = vr_we ? addr_mem[head_q] : '0;
    vr_wdata = vr_we ? data_mem[head_q] : '0;

    full     = full_w;
    count    = cnt_q;
    ovf      = ovf_q;
    vscr_sat = sat_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      sat_q  <= 1'b0;
      cr6_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      sat_q  <= sat_d;
      cr6_q  <= cr6_d;
    end
  end

  // Storage needs no reset: the head is gated off whenever the count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= vrt_addr;
      data_mem[tail_q] <= vrt;
      sat_mem[tail_q]  <= sat;
      cr6_mem[tail_q]  <= cr6;
      rc_mem[tail_q]   <= rc;
    end
  end

endmodule

// File: tb/tb_vsfx_wb.sv
// Scoreboard bench for vsfx_wb: a queue-based model predicts occupancy and flags, a monitor
// checks every retired write against the expected in-order stream.
module tb_vsfx_wb;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 128;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          sat;
    logic [3:0]    cr6;
    logic          rc;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          vrt_en = 1'b0;
  logic [DW-1:0] vrt = '0;
  logic          sat = 1'b0;
  logic [3:0]    cr6 = '0;
  logic          rc = 1'b0;
  logic [AW-1:0] vrt_addr = '0;
  logic          vscr_clr = 1'b0;
  logic          wb_ready = 1'b0;
  logic          vr_we, cr6_we, vscr_sat, full, ovf;
  logic [AW-1:0] vr_waddr;
  logic [DW-1:0] vr_wdata;
  logic [3:0]    cr6_out;
  logic [2:0]    count;

  vsfx_wb #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .vrt_en(vrt_en), .vrt(vrt), .sat(sat), .cr6(cr6), .rc(rc),
    .vrt_addr(vrt_addr), .vscr_clr(vscr_clr), .wb_ready(wb_ready), .vr_we(vr_we),
    .vr_waddr(vr_waddr), .vr_wdata(vr_wdata), .cr6_we(cr6_we), .cr6_out(cr6_out),
    .vscr_sat(vscr_sat), .full(full), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  ent_t m_q[$];    // model FIFO contents
  ent_t exp_q[$];  // scoreboard of accepted results, popped by the monitor
  logic m_sat = 1'b0;
  logic m_ovf = 1'b0;
  logic [3:0] mon_cr6 = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input int a, input logic [DW-1:0] d, input logic s,
                              input logic [3:0] c, input logic r);
    ent_t e;
    e.addr = AW'(a); e.data = d; e.sat = s; e.cr6 = c; e.rc = r;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    return mk($urandom_range(0, 31), {$urandom, $urandom, $urandom, $urandom},
              1'($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom_range(0, 1)));
  endfunction

  // Drive one cycle of stimulus, advance the model, then check the state after the edge.
  task automatic step(input logic en, input ent_t e, input logic rdy, input logic clr);
    logic pop_m, push_m;
    ent_t h;
    vrt_en = en; vrt_addr = e.addr; vrt = e.data; sat = e.sat; cr6 = e.cr6; rc = e.rc;
    wb_ready = rdy; vscr_clr = clr;
    pop_m  = (m_q.size() != 0) && rdy;
    push_m = en && ((m_q.size() < DEPTH) || pop_m);
    if (clr) m_sat = 1'b0;
    if (pop_m) begin
      h = m_q.pop_front();
      if (h.sat) m_sat = 1'b1;
    end
    if (push_m) begin
      m_q.push_back(e);
      exp_q.push_back(e);
    end else if (en) begin
      m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("count", count, m_q.size());
    chk("full", full, m_q.size() == DEPTH);
    chk("vr_we", vr_we, m_q.size() != 0);
    chk("ovf", ovf, m_ovf);
    chk("vscr_sat", vscr_sat, m_sat);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_vr_we"}, vr_we, 0);
    chk({tag, "_waddr"}, vr_waddr, 0);
    chk({tag, "_wdata"}, vr_wdata, 0);
    chk({tag, "_cr6_we"}, cr6_we, 0);
    chk({tag, "_cr6_out"}, cr6_out, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_sat"}, vscr_sat, 0);
  endtask

  // Asynchronous reset raised between clock edges, held across one rising edge.
  task automatic mid_reset(input string tag);
    vrt_en = 1'b0; vscr_clr = 1'b0;
    #2 rst = 1'b1;
    #1 chk_zero_outs(tag);
    m_q.delete(); exp_q.delete();
    m_sat = 1'b0; m_ovf = 1'b0; mon_cr6 = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (vr_we && wb_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0h expected no write", vr_waddr);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("wr_addr", vr_waddr, e.addr);
          chk("wr_data", vr_wdata, e.data);
          chk("cr6_we", cr6_we, e.rc);
          if (e.rc) begin
            chk("cr6_out_wr", cr6_out, e.cr6);
            mon_cr6 = e.cr6;
          end else begin
            chk("cr6_out_hold", cr6_out, mon_cr6);
          end
        end
      end else begin
        chk("cr6_we_idle", cr6_we, 0);
        chk("cr6_out_idle", cr6_out, mon_cr6);
        if (vr_we && exp_q.size() != 0) begin
          chk("stall_addr", vr_waddr, exp_q[0].addr);
          chk("stall_data", vr_wdata, exp_q[0].data);
        end
        if (!vr_we) begin
          chk("empty_addr", vr_waddr, 0);
          chk("empty_data", vr_wdata, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] sat_vec;
    #1 rst = 1'b1;
    #1 chk_zero_outs("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Single result, retired the cycle after it is pushed.
    step(1'b1, mk(3, 128'h0000_0001_0000_0002_0000_0003_0000_0004, 1'b0, 4'h0, 1'b0),
         1'b1, 1'b0);
    chk("t1_head_addr", vr_waddr, 3);
    idle(1, 1'b1);

    // Fill to DEPTH, then push while popping: count stays at DEPTH and pointers wrap.
    for (int i = 1; i <= 4; i++) step(1'b1, mk(i, DW'(i * 17), 1'b0, 4'h0, 1'b0), 1'b0, 1'b0);
    for (int i = 5; i <= 8; i++) step(1'b1, mk(i, DW'(i * 17), 1'b0, 4'h0, 1'b0), 1'b1, 1'b0);
    idle(5, 1'b1);

    // Sticky SAT: vaddsws 0x7FFFFFFF + 1 saturates each lane.
    sat_vec = {4{32'h7FFF_FFFF}};
    step(1'b1, mk(9, sat_vec, 1'b1, 4'h0, 1'b0), 1'b1, 1'b0);
    step(1'b1, mk(10, DW'(5), 1'b0, 4'h0, 1'b0), 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, mk(11, sat_vec, 1'b1, 4'h0, 1'b0), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);  // clear coincides with the sat pop
    idle(1, 1'b1);

    // Record form: only the rc=1 result strobes CR6.
    step(1'b1, mk(12, DW'(1), 1'b0, 4'b1000, 1'b1), 1'b1, 1'b0);
    step(1'b1, mk(13, DW'(2), 1'b0, 4'b0010, 1'b0), 1'b1, 1'b0);
    idle(2, 1'b1);

    // Overflow: five pushes with the port stalled, fifth dropped.
    for (int i = 1; i <= 5; i++) step(1'b1, mk(i, DW'(i * 3), 1'b0, 4'h0, 1'b0), 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(5, 1'b1);

    mid_reset("rst1");
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), rnd_ent(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));
    idle(6, 1'b1);

    // Three entries buffered, then reset mid-cycle: nothing further is written.
    mid_reset("rst2");
    for (int i = 0; i < 3; i++) step(1'b1, rnd_ent(), 1'b0, 1'b0);
    mid_reset("rst3");
    idle(4, 1'b1);
    step(1'b1, mk(21, DW'(77), 1'b0, 4'h0, 1'b0), 1'b1, 1'b0);
    idle(3, 1'b1);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vsfx_wb.md
Name: vsfx_wb

Overview:
Result write-back stage at the output end of the vector simple fixed-point unit.
- Accepts one result per cycle from the VSFX datapath: vrt_en, vrt, sat, cr6, plus the destination register and record bit forwarded from issue.
- Buffers results in a small in-order FIFO.
- Drains them into the vector register file write port under a ready handshake.
- Maintains the sticky VSCR[SAT] bit and the CR6 field update for record-form compares.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
AW, 5, vector register address width
DW, 128, vector data width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
vrt_en  input  1  result valid from VSFX
vrt  input  DW  result vector
sat  input  1  saturation flag of this result
cr6  input  4  CR6 value of this result
rc  input  1  record form: update CR6 when this result retires
vrt_addr  input  AW  destination vector register
vscr_clr  input  1  clear sticky SAT (mtvscr)
wb_ready  input  1  register file write port accepts this cycle
vr_we  output  1  write request to register file
vr_waddr  output  AW  write address (FIFO head)
vr_wdata  output  DW  write data (FIFO head)
cr6_we  output  1  CR6 write strobe
cr6_out  output  4  CR6 write value
vscr_sat  output  1  sticky VSCR[SAT]
full  output  1  FIFO full; issue must stall
count  output  log2(DEPTH)+1  occupancy
ovf  output  1  sticky: result dropped while full

Behaviour:
- Reset (async, rst=1): FIFO flushed, pointers and count = 0, vscr_sat = 0, ovf = 0. Outputs vr_we = 0, cr6_we = 0, vr_waddr = 0, vr_wdata = 0, cr6_out = 0, full = 0.
- Reset asserted mid-operation discards all buffered results; none are written.
- Entry format: {vrt_addr, vrt, sat, cr6, rc}.
- Push: vrt_en=1 and (count<DEPTH or pop this cycle). The entry is written at the tail.
- Push while full with no pop: entry dropped, ovf set to 1 and held until reset, no other state change.
- Pop: vr_we=1 and wb_ready=1. The head retires and the head pointer advances.
- vr_we = (count != 0).
  - vr_waddr and vr_wdata reflect the head entry combinationally from FIFO storage.
  - When count = 0 they are held at 0.
- Latency: a result pushed in cycle N is visible at the head no earlier than N+1. There is no same-cycle bypass.
- Ordering: strictly in order; results retire in push order.
- Handshake: vr_we, vr_waddr and vr_wdata are stable until wb_ready. A deasserted wb_ready holds the head indefinitely.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop:
  - Count is unchanged.
  - This is legal at count=DEPTH: the incoming entry takes the freed slot.
  - This is legal at count=0 only if an entry is at the head, which is impossible, so at count=0 only the push occurs.
- full = (count == DEPTH), registered-state derived, no combinational path from vrt_en.
- SAT: on each pop whose entry sat=1, vscr_sat is set at the next edge.
  - vscr_clr clears it.
  - If vscr_clr and a sat=1 pop occur in the same cycle, set wins, because the retiring result is younger than the mtvscr.
- CR6: on each pop whose entry rc=1, cr6_we pulses for that same cycle and cr6_out = entry cr6.
  - Otherwise cr6_we = 0 and cr6_out holds its last written value.

Test Plan:
- Reset, then a single push (vrt_en=1, vrt_addr=5'd3, vrt=128'h0000_0001_..._0004, sat=0, rc=0) with wb_ready=1 -> next cycle vr_we=1, vr_waddr=3, vr_wdata matches; following cycle count=0, vr_we=0.
- wb_ready=0, push 5 results (addr 1..5) on consecutive cycles -> full=1 after the 4th; the 5th is dropped and ovf=1. Then wb_ready=1 -> writes addr 1,2,3,4 on 4 consecutive cycles, with no addr 5.
- Fill to 4 with wb_ready=1 held and a push each cycle -> count stays 4; an 8-push stream retires addr 1..8 in order; pointer wrap verified and ovf=0.
- Push a result with sat=1 (vaddsws of 32'h7FFFFFFF+1) -> vscr_sat=1 the cycle after its write; later sat=0 results leave it at 1; vscr_clr -> 0; vscr_clr in the same cycle as a sat=1 pop -> vscr_sat=1.
- Push rc=1, cr6=4'b1000 then rc=0, cr6=4'b0010 -> one cr6_we pulse with cr6_out=4'b1000 aligned to the first write; none for the second.
- 3 entries buffered, assert rst for one cycle asynchronously mid-cycle -> outputs immediately 0, count=0, and no further vr_we until a new push.
